// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single synchronous data-RAM port between instruction fetch (IF)
//   and the load/store unit (LS). At most one request is granted per cycle
//   (combinationally, in the request cycle), and a small FSM remembers who owns
//   the read data that the RAM returns on the following cycle. Byte/half
//   extraction is left to the write-back stage; the full word is routed here.
//
//   LS normally has priority. A streak counter tracks consecutive LS grants
//   taken while IF is waiting; once it reaches STARVE_MAX, IF gets one grant.
//
// Ports
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   if_req/if_addr               IF read request, held until if_gnt
//   if_gnt                       IF request issued to RAM this cycle
//   if_rvalid/if_rdata           IF read word, one cycle after if_gnt
//   ls_req/ls_we/ls_addr         LS request (we=1 store), held until ls_gnt
//   ls_wdata/ls_wstrb            lane-aligned store data and byte enables
//   ls_gnt                       LS request issued to RAM this cycle
//   ls_rvalid/ls_rdata           LS load word, one cycle after a load's ls_gnt
//   ram_en/ram_we/ram_addr/ram_wdata   RAM command (word-aligned address)
//   ram_rdata                    RAM read data, one cycle after a read command
//
// Read-owner FSM
//   state   | meaning
//   S_IDLE  | no read outstanding; RAM data this cycle belongs to nobody
//   S_RD_IF | IF read issued last cycle; RAM data goes to IF
//   S_RD_LS | LS load issued last cycle; RAM data goes to LS
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,

  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  input  logic [3:0]    ls_wstrb,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,

  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD_IF = 2'd1,
    S_RD_LS = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;

  logic          starve;
  logic          store_gnt;

  assign starve = (streak_q == SW'(STARVE_MAX));

  // Grant decision. Reset suppresses every grant so the RAM sees nothing
  // while the arbiter is held.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst) begin
      if (ls_req && !(if_req && starve)) begin
        ls_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  assign store_gnt = ls_gnt & ls_we;

  // RAM command. Low address bits are dropped: the RAM is word addressed and
  // lane selection for stores is carried entirely by ram_we.
  always_comb begin
    ram_en    = if_gnt | ls_gnt;
    ram_addr  = '0;
    ram_we    = 4'b0000;
    ram_wdata = '0;
    if (ls_gnt) begin
      ram_addr = {ls_addr[AW-1:2], 2'b00};
    end else if (if_gnt) begin
      ram_addr = {if_addr[AW-1:2], 2'b00};
    end
    if (store_gnt) begin
      ram_we    = ls_wstrb;
      ram_wdata = ls_wdata;
    end
  end

  // Streak only counts while IF is actually waiting; it saturates so that IF
  // wins every contested cycle until it is served.
  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (ls_gnt && !starve) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_comb begin
    state_d = S_IDLE;
    if (if_gnt) begin
      state_d = S_RD_IF;
    end else if (ls_gnt && !ls_we) begin
      state_d = S_RD_LS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Responses are gated by rst as well so a read issued the cycle before
  // reset is dropped rather than delivered while the block is held.
  always_comb begin
    if_rvalid = !rst && (state_q == S_RD_IF);
    ls_rvalid = !rst && (state_q == S_RD_LS);
    if_rdata  = if_rvalid ? ram_rdata : '0;
    ls_rdata  = ls_rvalid ? ram_rdata : '0;
  end

endmodule
